// File: rtl/arm_pkg.sv
// Shared types and widths for the ARM-style pipeline stages.
package arm_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// Contents are never reset.
module data_memory
    import arm_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: fixed-latency data-memory access that stalls upstream via freeze,
// then registers results into MEM/WB (latency 1 when idle, WAIT_CYCLES+1 for loads/stores).
module mem_stage
    import arm_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 4,
    parameter int ADDR_BASE   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_EN_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] val_Rm_in,
    input  logic [REG_W-1:0]  Dest_in,
    output logic              freeze,
    output logic              WB_EN_out,
    output logic              MEM_R_EN_out,
    output logic [DATA_W-1:0] ALU_result_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [REG_W-1:0]  Dest_out
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

    mem_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              stall;
    logic              mem_req, store, load, mem_we;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] rdata;

    logic              wb_en_q, mem_r_en_q;
    logic [DATA_W-1:0] alu_result_q, mem_data_q;
    logic [REG_W-1:0]  dest_q;

    assign mem_req = MEM_R_EN_in | MEM_W_EN_in;
    assign store   = MEM_W_EN_in;
    assign load    = MEM_R_EN_in & ~MEM_W_EN_in;

    // Offset from the base, word-aligned; the cast drops the high bits so addresses wrap.
    assign idx = AW'((ALU_result_in - DATA_W'(ADDR_BASE)) >> 2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req && (WAIT_CYCLES > 0)) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CW'(1);
                end
            end
            BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset must also suppress the write so an aborted store never lands.
    assign freeze = stall & ~rst;
    assign mem_we = store & ~stall & ~rst;

    data_memory #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_dmem (
        .clk  (clk),
        .we   (mem_we),
        .idx  (idx),
        .wdata(val_Rm_in),
        .rdata(rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            dest_q       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall) begin
                wb_en_q    <= 1'b0;
                mem_r_en_q <= 1'b0;
            end else begin
                wb_en_q      <= WB_EN_in;
                mem_r_en_q   <= load;
                alu_result_q <= ALU_result_in;
                dest_q       <= Dest_in;
                if (load) begin
                    mem_data_q <= rdata;
                end
            end
        end
    end

    assign WB_EN_out      = wb_en_q;
    assign MEM_R_EN_out   = mem_r_en_q;
    assign ALU_result_out = alu_result_q;
    assign mem_data_out   = mem_data_q;
    assign Dest_out       = dest_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage with a word-array reference model; covers the
// default 4-wait build and a zero-wait build side by side.
module tb_mem_stage;
    import arm_pkg::*;

    localparam int DEPTH = 64;
    localparam int WAITS = 4;
    localparam int BASE  = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_in = 1'b0, rd_in = 1'b0, wr_in = 1'b0;
    logic [31:0] alu_in = '0, rm_in = '0;
    logic [3:0]  dest_in = '0;

    logic        f4, wb4, rd4, fz, wbz, rdz;
    logic [31:0] alu4, md4, aluz, mdz;
    logic [3:0]  dest4, destz;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS), .ADDR_BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .WB_EN_in(wb_in), .MEM_R_EN_in(rd_in), .MEM_W_EN_in(wr_in),
        .ALU_result_in(alu_in), .val_Rm_in(rm_in), .Dest_in(dest_in),
        .freeze(f4), .WB_EN_out(wb4), .MEM_R_EN_out(rd4),
        .ALU_result_out(alu4), .mem_data_out(md4), .Dest_out(dest4)
    );

    mem_stage #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_BASE(BASE)) dut_z (
        .clk(clk), .rst(rst),
        .WB_EN_in(wb_in), .MEM_R_EN_in(rd_in), .MEM_W_EN_in(wr_in),
        .ALU_result_in(alu_in), .val_Rm_in(rm_in), .Dest_in(dest_in),
        .freeze(fz), .WB_EN_out(wbz), .MEM_R_EN_out(rdz),
        .ALU_result_out(aluz), .mem_data_out(mdz), .Dest_out(destz)
    );

    // Which build is under observation.
    bit zsel = 1'b0;
    wire        o_fz   = zsel ? fz    : f4;
    wire        o_wb   = zsel ? wbz   : wb4;
    wire        o_rd   = zsel ? rdz   : rd4;
    wire [31:0] o_alu  = zsel ? aluz  : alu4;
    wire [31:0] o_md   = zsel ? mdz   : md4;
    wire [3:0]  o_dest = zsel ? destz : dest4;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: model memory plus the expected MEM/WB contents.
    logic [31:0] mdl_mem [DEPTH];
    bit          mdl_vld [DEPTH];
    logic        exp_wb, exp_rd;
    logic [31:0] exp_alu, exp_md;
    logic [3:0]  exp_dest;
    bit          md_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - 32'(BASE);
        return int'((off / 4) % DEPTH);
    endfunction

    // Present one op just after a rising edge and follow it through to write-back.
    task automatic do_op(input bit wb, input bit r, input bit w,
                         input logic [31:0] addr, input logic [31:0] data, input logic [3:0] dest);
        int nfz;
        int widx;
        int want;
        wb_in = wb; rd_in = r; wr_in = w; alu_in = addr; rm_in = data; dest_in = dest;
        nfz = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!o_fz) break;
            nfz++;
            if (nfz >= 2) begin
                check("bubble_wb", 32'(o_wb), 32'd0);
                check("bubble_rd", 32'(o_rd), 32'd0);
            end
            @(posedge clk); #1;
        end
        if (nfz > 0) begin
            check("complete_cycle_wb", 32'(o_wb), 32'd0);
            check("complete_cycle_rd", 32'(o_rd), 32'd0);
        end
        want = ((r || w) && !zsel) ? WAITS : 0;
        check("stall_cycles", 32'(nfz), 32'(want));

        widx = word_of(addr);
        exp_wb   = wb;
        exp_rd   = r && !w;
        exp_alu  = addr;
        exp_dest = dest;
        if (w) begin
            mdl_mem[widx] = data;
            mdl_vld[widx] = 1'b1;
        end else if (r) begin
            exp_md   = mdl_mem[widx];
            md_known = mdl_vld[widx];
        end

        @(posedge clk); #1;
        check("wb_en", 32'(o_wb), 32'(exp_wb));
        check("mem_r_en", 32'(o_rd), 32'(exp_rd));
        check("alu_result", o_alu, exp_alu);
        check("dest", 32'(o_dest), 32'(exp_dest));
        if (md_known) check("mem_data", o_md, exp_md);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_freeze"}, 32'(o_fz), 32'd0);
        check({tag, "_wb"}, 32'(o_wb), 32'd0);
        check({tag, "_rd"}, 32'(o_rd), 32'd0);
        check({tag, "_alu"}, o_alu, 32'd0);
        check({tag, "_md"}, o_md, 32'd0);
        check({tag, "_dest"}, 32'(o_dest), 32'd0);
    endtask

    task automatic rand_op();
        logic [31:0] a;
        int kind;
        kind = $urandom_range(0, 9);
        if ($urandom_range(0, 7) == 0) a = $urandom();
        else a = 32'(BASE) + 32'($urandom_range(0, 4 * DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
        do_op(1'($urandom), (kind >= 3 && kind <= 6) || kind == 9, kind >= 7,
              a, $urandom(), 4'($urandom));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl_vld[i] = 1'b0;
        exp_md = '0; md_known = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the default build.
        do_op(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3);
        do_op(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4'd0);
        do_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd5);
        check("load_1028", o_md, 32'hDEAD_BEEF);
        do_op(1'b0, 1'b0, 1'b1, 32'd1280, 32'h1234, 4'd1);
        do_op(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd2);
        check("wrap_load", o_md, 32'h1234);
        do_op(1'b1, 1'b1, 1'b1, 32'd1036, 32'h0BAD_F00D, 4'd7);

        // Fill memory so every later load has a known value.
        for (int i = 0; i < DEPTH; i++)
            do_op(1'b0, 1'b0, 1'b1, 32'(BASE + 4 * i), $urandom(), 4'd0);
        for (int i = 0; i < 120; i++) rand_op();

        // Reset in the middle of a store: nothing must reach memory.
        do_op(1'b0, 1'b0, 1'b1, 32'd1028, 32'hCAFE_0001, 4'd0);
        wb_in = 1'b0; rd_in = 1'b0; wr_in = 1'b1; alu_in = 32'd1028; rm_in = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_freeze", 32'(o_fz), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_state("abort");
        wr_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_md = '0; md_known = 1'b1;
        @(posedge clk); #1;
        do_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd4);
        check("after_abort", o_md, 32'hCAFE_0001);

        // Zero-wait build: its memory history differs, so restart the model's knowledge.
        zsel = 1'b1;
        for (int i = 0; i < DEPTH; i++) mdl_vld[i] = 1'b0;
        md_known = 1'b0;
        do_op(1'b0, 1'b0, 1'b1, 32'd1032, 32'hA5A5_A5A5, 4'd0);
        do_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd6);
        check("zw_load", o_md, 32'hA5A5_A5A5);
        for (int i = 0; i < 80; i++) rand_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
